// File: rtl/rysy_pkg.sv
// -----------------------------------------------------------------------------
// rysy_pkg
// Shared definitions for the core's memory-side blocks.
//   REG_LEN          : architectural register / data-bus width
//   dbc_state_e      : data_bus_ctrl FSM encodings (2-bit)
//   DBC_TIMEOUT_DEF  : default abort limit for data_bus_ctrl, in cycles
//   dbc_word_align() : clears the byte-offset bits of a byte address
// -----------------------------------------------------------------------------
package rysy_pkg;

   localparam int REG_LEN = 32;

   typedef enum logic [1:0] {
      DBC_IDLE = 2'd0,
      DBC_REQ  = 2'd1,
      DBC_WAIT = 2'd2
   } dbc_state_e;

   localparam int unsigned DBC_TIMEOUT_DEF = 255;

   // Memory is word-addressed on the bus; lane selection is carried by the
   // byte enables, so the low two address bits are always forced to zero.
   function automatic logic [REG_LEN-1:0] dbc_word_align(input logic [REG_LEN-1:0] addr);
      return addr & ~REG_LEN'(3);
   endfunction

endpackage

// File: rtl/dbc_timer.sv
// -----------------------------------------------------------------------------
// dbc_timer
// Wait-time counter for data_bus_ctrl. Counts cycles spent waiting for a
// memory event and flags when the abort limit has been reached.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : restart the count from zero (has priority over en)
//   en        : one more cycle elapsed without the awaited event
//   expired   : count has reached TIMEOUT-1; combined with an absent event
//               this means the current wait has used its TIMEOUT cycles
// -----------------------------------------------------------------------------
module dbc_timer
   import rysy_pkg::*;
#(
   parameter int unsigned TIMEOUT = DBC_TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         // Saturate at the terminal count; the FSM leaves on expiry anyway.
         cnt <= cnt + CW'(1);
      end
   end

   assign expired = (cnt == TC);

endmodule

// File: rtl/data_bus_ctrl.sv
// -----------------------------------------------------------------------------
// data_bus_ctrl
// Turns a single-cycle core load/store request into a req/gnt/rvalid memory
// transaction, stalls the core while it is outstanding, returns load data and
// aborts with an error if memory does not answer within TIMEOUT cycles.
// One transaction in flight at a time.
//
// Ports
//   clk, rst                     : clock, asynchronous active-high reset
//   lsu_req/we/addr/be/wdata     : core request (held until lsu_stall is low)
//   lsu_stall                    : core must hold its instruction (comb.)
//   lsu_done, lsu_err            : one-cycle completion / error pulses
//   lsu_rdata                    : load word, valid while lsu_done=1
//   mem_req/we/be/addr/wdata     : registered memory request
//   mem_gnt                      : memory accepted the request
//   mem_rvalid, mem_rdata        : load data return
//
// FSM
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   DBC_IDLE | no transaction; capture a new core request
//   DBC_REQ  | mem_req high, fields stable, waiting for mem_gnt
//   DBC_WAIT | load granted, waiting for mem_rvalid
// -----------------------------------------------------------------------------
module data_bus_ctrl
   import rysy_pkg::*;
#(
   parameter int unsigned TIMEOUT = DBC_TIMEOUT_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               lsu_req,
   input  logic               lsu_we,
   input  logic [REG_LEN-1:0] lsu_addr,
   input  logic [3:0]         lsu_be,
   input  logic [REG_LEN-1:0] lsu_wdata,
   output logic               lsu_stall,
   output logic               lsu_done,
   output logic               lsu_err,
   output logic [REG_LEN-1:0] lsu_rdata,
   output logic               mem_req,
   output logic               mem_we,
   output logic [3:0]         mem_be,
   output logic [REG_LEN-1:0] mem_addr,
   output logic [REG_LEN-1:0] mem_wdata,
   input  logic               mem_gnt,
   input  logic               mem_rvalid,
   input  logic [REG_LEN-1:0] mem_rdata
);

   dbc_state_e         state, state_nxt;
   logic               capture;
   logic               done_nxt;
   logic               err_nxt;
   logic [REG_LEN-1:0] rdata_nxt;
   logic               tmr_clr;
   logic               tmr_en;
   logic               tmr_expired;

   dbc_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   // Any state change restarts the wait count, which covers entry to both
   // REQ and WAIT; in IDLE the counter simply sits at zero.
   assign tmr_clr = (state_nxt != state);

   // lsu_done masks the still-high request in the completion cycle so the
   // core can retire without the same request being captured again.
   assign lsu_stall = (state != DBC_IDLE) | (lsu_req & ~lsu_done);

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      rdata_nxt = '0;
      tmr_en    = 1'b0;

      unique case (state)
         DBC_IDLE: begin
            if (lsu_req && !lsu_done) begin
               capture = 1'b1;
               if (lsu_be == 4'b0000) begin
                  // Nothing to access: complete with an error, no bus cycle.
                  done_nxt = 1'b1;
                  err_nxt  = 1'b1;
               end else begin
                  state_nxt = DBC_REQ;
               end
            end
         end

         DBC_REQ: begin
            if (mem_gnt) begin
               if (mem_we) begin
                  done_nxt  = 1'b1;
                  state_nxt = DBC_IDLE;
               end else if (mem_rvalid) begin
                  done_nxt  = 1'b1;
                  rdata_nxt = mem_rdata;
                  state_nxt = DBC_IDLE;
               end else begin
                  state_nxt = DBC_WAIT;
               end
            end else if (tmr_expired) begin
               done_nxt  = 1'b1;
               err_nxt   = 1'b1;
               state_nxt = DBC_IDLE;
            end else begin
               tmr_en = 1'b1;
            end
         end

         DBC_WAIT: begin
            if (mem_rvalid) begin
               done_nxt  = 1'b1;
               rdata_nxt = mem_rdata;
               state_nxt = DBC_IDLE;
            end else if (tmr_expired) begin
               done_nxt  = 1'b1;
               err_nxt   = 1'b1;
               state_nxt = DBC_IDLE;
            end else begin
               tmr_en = 1'b1;
            end
         end

         default: begin
            state_nxt = DBC_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= DBC_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Request fields come straight from the capture registers, so they stay
   // stable for the whole REQ residence.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we    <= 1'b0;
         mem_be    <= 4'b0000;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (capture) begin
         mem_we    <= lsu_we;
         mem_be    <= lsu_be;
         mem_addr  <= dbc_word_align(lsu_addr);
         mem_wdata <= lsu_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req   <= 1'b0;
         lsu_done  <= 1'b0;
         lsu_err   <= 1'b0;
         lsu_rdata <= '0;
      end else begin
         mem_req   <= (state_nxt == DBC_REQ);
         lsu_done  <= done_nxt;
         lsu_err   <= err_nxt;
         lsu_rdata <= rdata_nxt;
      end
   end

endmodule

// File: tb/tb_data_bus_ctrl.sv
module tb_data_bus_ctrl;
   import rysy_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic               lsu_req;
   logic               lsu_we;
   logic [REG_LEN-1:0] lsu_addr;
   logic [3:0]         lsu_be;
   logic [REG_LEN-1:0] lsu_wdata;
   logic               lsu_stall;
   logic               lsu_done;
   logic               lsu_err;
   logic [REG_LEN-1:0] lsu_rdata;
   logic               mem_req;
   logic               mem_we;
   logic [3:0]         mem_be;
   logic [REG_LEN-1:0] mem_addr;
   logic [REG_LEN-1:0] mem_wdata;
   logic               mem_gnt;
   logic               mem_rvalid;
   logic [REG_LEN-1:0] mem_rdata;

   typedef struct packed {
      logic               err;
      logic [REG_LEN-1:0] rdata;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   data_bus_ctrl #(.TIMEOUT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .lsu_req    (lsu_req),
      .lsu_we     (lsu_we),
      .lsu_addr   (lsu_addr),
      .lsu_be     (lsu_be),
      .lsu_wdata  (lsu_wdata),
      .lsu_stall  (lsu_stall),
      .lsu_done   (lsu_done),
      .lsu_err    (lsu_err),
      .lsu_rdata  (lsu_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_be     (mem_be),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   // Scoreboard: every completion pulse pops the oldest expected result.
   always @(negedge clk) begin
      if (!rst && lsu_done === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_done t=%0t err=%b rdata=%h required no completion",
                     $time, lsu_err, lsu_rdata);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if ({lsu_err, lsu_rdata} !== {e.err, e.rdata}) begin
               errors++;
               $display("FAIL sb_result t=%0t err=%b rdata=%h required err=%b rdata=%h",
                        $time, lsu_err, lsu_rdata, e.err, e.rdata);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   task automatic idle_inputs();
      lsu_req    = 1'b0;
      lsu_we     = 1'b0;
      lsu_addr   = '0;
      lsu_be     = 4'b0000;
      lsu_wdata  = '0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
   endtask

   // Cycle 0 is the cycle the request is presented; per cycle the expected
   // mem_req window, stall, done and err are derived from the schedule.
   task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input logic tie_gnt, input int gnt_c, input int rv_c,
                          input int stray_c, input logic [31:0] rv_d,
                          input int done_c, input logic err,
                          input int req_lo, input int req_hi);
      exp_t e;
      logic exp_req;
      e.err   = err;
      e.rdata = (err || we) ? 32'h0 : rv_d;
      sb_q.push_back(e);
      for (int c = 0; c <= done_c + 3; c++) begin
         @(posedge clk); #1;
         lsu_req    = (c <= done_c);
         lsu_we     = we;
         lsu_addr   = addr;
         lsu_be     = be;
         lsu_wdata  = wdata;
         mem_gnt    = tie_gnt || (c == gnt_c);
         mem_rvalid = (c == rv_c) || (c == stray_c);
         mem_rdata  = (c == rv_c) ? rv_d : $urandom;
         @(negedge clk);
         exp_req = (c >= req_lo) && (c <= req_hi);
         checks++;
         if (mem_req !== exp_req) begin
            errors++;
            $display("FAIL %s mem_req c=%0d got %b required %b", name, c, mem_req, exp_req);
         end
         checks++;
         if (lsu_stall !== (c < done_c)) begin
            errors++;
            $display("FAIL %s lsu_stall c=%0d got %b required %b", name, c, lsu_stall, c < done_c);
         end
         checks++;
         if ({lsu_done, lsu_err} !== {c == done_c, (c == done_c) && err}) begin
            errors++;
            $display("FAIL %s done_err c=%0d got %b%b required %b%b", name, c,
                     lsu_done, lsu_err, c == done_c, (c == done_c) && err);
         end
         if (exp_req) begin
            checks++;
            if ({mem_we, mem_be, mem_addr, mem_wdata} !== {we, be, addr & 32'hFFFF_FFFC, wdata}) begin
               errors++;
               $display("FAIL %s mem_fields c=%0d got we=%b be=%b addr=%h wdata=%h required we=%b be=%b addr=%h wdata=%h",
                        name, c, mem_we, mem_be, mem_addr, mem_wdata,
                        we, be, addr & 32'hFFFF_FFFC, wdata);
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      #12;
      checks++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, lsu_done, lsu_err, lsu_rdata, lsu_stall} !== '0) begin
         errors++;
         $display("FAIL reset_values got req=%b we=%b be=%b addr=%h wdata=%h done=%b err=%b rdata=%h stall=%b required all 0",
                  mem_req, mem_we, mem_be, mem_addr, mem_wdata, lsu_done, lsu_err, lsu_rdata, lsu_stall);
      end
      lsu_req = 1'b1;
      #1;
      checks++;
      if (lsu_stall !== 1'b1) begin
         errors++;
         $display("FAIL reset_stall_follows_req got %b required 1", lsu_stall);
      end
      lsu_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_store();
      run_txn("store_gnt_tied", 1'b1, 32'h0000_1003, 4'b1000, 32'hAB00_0000,
              1'b1, -1, -1, -1, 32'h0, 2, 1'b0, 1, 1);
   endtask

   task automatic test_load();
      run_txn("load_gnt3_rv6", 1'b0, 32'h0000_2004, 4'b1111, 32'h0,
              1'b0, 3, 6, 2, 32'hDEAD_BEEF, 7, 1'b0, 1, 3);
   endtask

   task automatic test_load_same_cycle();
      run_txn("load_gnt_rv_same", 1'b0, 32'h0000_0042, 4'b1111, 32'h0,
              1'b0, 1, 1, 4, 32'h1234_5678, 2, 1'b0, 1, 1);
   endtask

   task automatic test_timeout();
      run_txn("timeout_req", 1'b1, 32'h0000_0010, 4'b0011, 32'h0000_5A5A,
              1'b0, -1, -1, -1, 32'h0, 5, 1'b1, 1, 4);
      run_txn("timeout_wait", 1'b0, 32'h0000_0020, 4'b1111, 32'h0,
              1'b0, 1, -1, -1, 32'h0, 6, 1'b1, 1, 1);
   endtask

   task automatic test_zero_be();
      run_txn("zero_be", 1'b1, 32'h0000_0030, 4'b0000, 32'hFFFF_FFFF,
              1'b1, -1, -1, -1, 32'h0, 1, 1'b1, 1, 0);
   endtask

   task automatic test_reset_mid();
      // Abandon a load in WAIT.
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         lsu_req  = 1'b1;
         lsu_we   = 1'b0;
         lsu_addr = 32'h0000_2000;
         lsu_be   = 4'b1111;
         mem_gnt  = (c == 1);
      end
      @(negedge clk);
      checks++;
      if ({mem_req, mem_addr, lsu_stall} !== {1'b0, 32'h0000_2000, 1'b1}) begin
         errors++;
         $display("FAIL rst_mid_pre_wait got req=%b addr=%h stall=%b required 0 00002000 1",
                  mem_req, mem_addr, lsu_stall);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, lsu_done, lsu_err, lsu_rdata} !== '0
          || lsu_stall !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_wait got req=%b be=%b addr=%h done=%b err=%b rdata=%h stall=%b required zeros stall=1",
                  mem_req, mem_be, mem_addr, lsu_done, lsu_err, lsu_rdata, lsu_stall);
      end
      idle_inputs();
      @(posedge clk); #1;
      rst = 1'b0;
      // Abandon a store in REQ: mem_req must drop without waiting for a clock.
      @(posedge clk); #1;
      lsu_req  = 1'b1;
      lsu_we   = 1'b1;
      lsu_addr = 32'h0000_0044;
      lsu_be   = 4'b0001;
      @(posedge clk); #1;
      checks++;
      if (mem_req !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_req_pre got mem_req=%b required 1", mem_req);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_req got mem_req=%b addr=%h required 0 00000000", mem_req, mem_addr);
      end
      idle_inputs();
      @(posedge clk); #1;
      rst = 1'b0;
      run_txn("store_after_rst", 1'b1, 32'h0000_0C0D, 4'b0110, 32'h00C0_FF00,
              1'b1, -1, -1, -1, 32'h0, 2, 1'b0, 1, 1);
   endtask

   task automatic test_back_to_back();
      logic exp_req [7]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic exp_done [7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic exp_stall [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      exp_t e;
      e.err = 1'b0;
      e.rdata = '0;
      sb_q.push_back(e);
      sb_q.push_back(e);
      for (int c = 0; c < 7; c++) begin
         @(posedge clk); #1;
         lsu_req   = (c <= 5);
         lsu_we    = 1'b1;
         mem_gnt   = (c <= 5);
         lsu_addr  = (c < 3) ? 32'h0000_0300 : 32'h0000_0406;
         lsu_be    = (c < 3) ? 4'b1111 : 4'b1100;
         lsu_wdata = (c < 3) ? 32'h1111_2222 : 32'h3333_0000;
         @(negedge clk);
         checks++;
         if ({mem_req, lsu_done, lsu_stall} !== {exp_req[c], exp_done[c], exp_stall[c]}) begin
            errors++;
            $display("FAIL b2b c=%0d got req=%b done=%b stall=%b required req=%b done=%b stall=%b",
                     c, mem_req, lsu_done, lsu_stall, exp_req[c], exp_done[c], exp_stall[c]);
         end
         if (c == 4) begin
            checks++;
            if ({mem_be, mem_addr, mem_wdata} !== {4'b1100, 32'h0000_0404, 32'h3333_0000}) begin
               errors++;
               $display("FAIL b2b_second_fields got be=%b addr=%h wdata=%h required 1100 00000404 33330000",
                        mem_be, mem_addr, mem_wdata);
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_load_same_cycle();
      test_timeout();
      test_zero_be();
      test_reset_mid();
      test_back_to_back();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got %0d pending completions required 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_bus_ctrl.md
# data_bus_ctrl

Sequential data-bus controller sitting directly downstream of the store-formatting stage (which produces byte enables and lane-aligned write data) and upstream of data memory. Converts a single-cycle core load/store request into a request/grant/response memory transaction, stalls the core while it is outstanding, captures load data, and aborts with an error after a programmable timeout. One transaction in flight at a time.

## Interface
- `TIMEOUT`, 255: max cycles spent waiting in REQ or WAIT before abort; legal range 1..65535.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `lsu_req`  in  1  core requests a load/store; held high until `lsu_stall` is low.
- `lsu_we`  in  1  1 = store, 0 = load.
- `lsu_addr`  in  `REG_LEN`  byte address.
- `lsu_be`  in  4  byte enables from store-formatting stage (loads: 4'b1111).
- `lsu_wdata`  in  `REG_LEN`  lane-aligned store data.
- `lsu_stall`  out  1  core must hold the current instruction.
- `lsu_done`  out  1  one-cycle completion pulse.
- `lsu_err`  out  1  one-cycle error pulse, coincident with `lsu_done`.
- `lsu_rdata`  out  `REG_LEN`  captured load word, valid while `lsu_done`=1.
- `mem_req`  out  1  memory request.
- `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`  out  1/4/`REG_LEN`/`REG_LEN`  registered request fields; `mem_addr[1:0]` always 2'b00.
- `mem_gnt`  in  1  memory accepted request.
- `mem_rvalid`  in  1  load data valid.
- `mem_rdata`  in  `REG_LEN`  load data.

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: if `lsu_req` and not `lsu_done`, capture we/addr (bits [1:0] zeroed)/be/wdata. Then go to REQ, or if `lsu_be`==0, go directly to IDLE with done+err (no memory access).
- REQ: `mem_req`=1, fields from capture registers and stable until grant.
  - `mem_gnt` with store -> IDLE, done.
  - `mem_gnt` with load -> WAIT.
  - If `mem_rvalid` is also high in the same cycle, capture `mem_rdata`, go to IDLE, assert done.
- WAIT: `mem_req`=0. `mem_rvalid` -> capture `mem_rdata` into `lsu_rdata`, go to IDLE, assert done.
- `lsu_stall` = (state != IDLE) | (`lsu_req` & ~`lsu_done`), combinational.
  - In the done cycle the core sees stall=0 and retires.
  - The still-high `lsu_req` is not re-captured.
- Ignored inputs: `mem_rvalid` in IDLE/REQ-without-grant; `mem_gnt` in IDLE/WAIT.
- Timeout: a counter of width $clog2(TIMEOUT+1) clears on entry to REQ and on entry to WAIT, and increments each cycle in REQ/WAIT while the awaited event is absent.
  - When it reaches TIMEOUT-1 with the event still absent: go to IDLE, done+err, `lsu_rdata`=0.
  - Residence in REQ or WAIT is therefore at most TIMEOUT cycles.
- Store done returns `lsu_rdata`=0.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `lsu_done`, `lsu_err` = 0; `mem_be`=0; `mem_addr`, `mem_wdata`, `lsu_rdata` = 0; counter 0.
- `lsu_stall` follows `lsu_req` combinationally, even during reset.
- `mem_req` is registered: it rises the cycle after `lsu_req` is captured.
- `lsu_done`, `lsu_err`, `lsu_rdata` are registered: they appear the cycle after the completing grant/rvalid/timeout.
- Store, zero-wait grant: req at cycle 0, `mem_req` at cycle 1, gnt at cycle 1, done at cycle 2. The core is stalled for cycles 0–1.
- Load, gnt and rvalid both at cycle 1: done at cycle 2 (same as store).
- Load, gnt at cycle 1, rvalid at cycle k: done at cycle k+1.
- Reset mid-transaction: `mem_req` drops asynchronously and the transaction is abandoned. The memory side must tolerate this.
- Back-to-back: a new request can be captured at cycle done+1, because `lsu_done` blocks capture only in its own cycle.

## Structure
- `rysy_pkg.vh` gains:
  - state encodings `DBC_IDLE`, `DBC_REQ`, `DBC_WAIT` (2-bit);
  - `DBC_TIMEOUT_DEF` (255).
- It continues to supply `REG_LEN`.
- The timeout counter is a natural sub-module, `dbc_timer` (clear, enable, expired output, parameter TIMEOUT).
- The FSM and capture registers live in `data_bus_ctrl`.

## Test plan
- Store, `mem_gnt` tied 1: addr 0x1003, be 4'b1000, wdata 0xAB000000 -> cycle 1 shows `mem_req`=1, `mem_addr`=0x1000, `mem_be`=4'b1000; cycle 2 shows `lsu_done`=1, `lsu_err`=0, `lsu_stall`=0.
- Load, gnt at cycle 3, rvalid at cycle 6 with 0xDEADBEEF -> `mem_req` high for cycles 1–3 only; cycle 7 shows `lsu_done`=1, `lsu_rdata`=0xDEADBEEF; stall high for cycles 0–6.
- Load with gnt and rvalid in the same cycle (cycle 1, data 0x12345678) -> done at cycle 2 with that data; a stray rvalid at cycle 4 is ignored.
- TIMEOUT=4, `mem_gnt` never asserted -> `mem_req` high for exactly 4 cycles (1–4); cycle 5 shows `lsu_done`=`lsu_err`=1, `lsu_rdata`=0; the FSM is back in IDLE.
- Store with `lsu_be`=0 -> no `mem_req`; next cycle shows done+err.
- Assert `rst` mid-WAIT -> all outputs 0 immediately; after release, a new store completes normally; two back-to-back stores are captured at cycles 0 and 3 with gnt tied 1.
